// File: rtl/decoder38_scan_pkg.sv
// Shared types and constants for the decoder38 scan sequencer.
package decoder38_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DWELL
   } scan_state_t;

   localparam int NUM_CH        = 8;
   localparam int IDX_W         = 3;
   localparam int BLANK_CYC_MAX = 15;
   localparam int BLANK_CNT_W   = $clog2(BLANK_CYC_MAX + 1);

endpackage

// File: rtl/decoder38_next_idx.sv
// Combinational channel search: lowest enabled index above cur_idx, else the lowest enabled index.
// Flags a wrap when nothing above cur_idx is enabled, and none when the mask is empty.
module decoder38_next_idx
   import decoder38_scan_pkg::*;
(
   input  logic [IDX_W-1:0]  cur_idx,
   input  logic [NUM_CH-1:0] mask,
   output logic [IDX_W-1:0]  next_idx,
   output logic              wrap,
   output logic              none
);

   logic [IDX_W-1:0] low_idx;
   logic [IDX_W-1:0] high_idx;
   logic             high_found;

   // Scanning downward leaves the lowest qualifying hit in each result.
   always_comb begin
      low_idx    = '0;
      high_idx   = '0;
      high_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            low_idx = IDX_W'(i);
            if (i > int'(cur_idx)) begin
               high_idx   = IDX_W'(i);
               high_found = 1'b1;
            end
         end
      end
   end

   assign next_idx = high_found ? high_idx : low_idx;
   assign wrap     = !high_found;
   assign none     = (mask == '0);

endmodule

// File: rtl/decoder38_scan_ctrl.sv
// Scan sequencer feeding a 3-to-8 decoder: walks w with a blanking gap and a dwell per channel.
// Define DECODER38_SCAN_MASK_EN to skip channels whose en_mask bit is clear.
module decoder38_scan_ctrl
   import decoder38_scan_pkg::*;
#(
   parameter int DWELL_W   = 16,
   parameter int BLANK_CYC = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               pol_in,
   input  logic [NUM_CH-1:0]  en_mask,
   output logic [IDX_W-1:0]   w,
   output logic               e,
   output logic               s,
   output logic               busy,
   output logic               step_pulse,
   output logic               done
);

   localparam logic [BLANK_CNT_W-1:0] BLANK_LD  = BLANK_CNT_W'(BLANK_CYC);
   localparam logic [DWELL_W-1:0]     DWELL_ONE = DWELL_W'(1);

   scan_state_t              state;
   logic [BLANK_CNT_W-1:0]   blank_cnt;
   logic [DWELL_W-1:0]       dwell_cnt;
   logic [DWELL_W-1:0]       dwell_lat;
   logic [DWELL_W-1:0]       dwell_eff;
   logic [IDX_W-1:0]         next_idx;
   logic [IDX_W-1:0]         first_idx;
   logic                     adv_wrap;
   logic                     mask_none;
   logic                     start_ok;

   assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;

`ifdef DECODER38_SCAN_MASK_EN
   logic [IDX_W-1:0] search_idx;

   // Searching from channel 7 while idle makes the wrap land on the lowest enabled channel.
   assign search_idx = (state == IDLE) ? IDX_W'(NUM_CH - 1) : w;

   decoder38_next_idx u_next_idx (
      .cur_idx  (search_idx),
      .mask     (en_mask),
      .next_idx (next_idx),
      .wrap     (adv_wrap),
      .none     (mask_none)
   );

   assign first_idx = next_idx;
`else
   logic unused_mask;

   assign unused_mask = ^en_mask;
   assign next_idx    = w + 1'b1;
   assign adv_wrap    = (w == IDX_W'(NUM_CH - 1));
   assign mask_none   = 1'b0;
   assign first_idx   = '0;
`endif

   assign start_ok = start && !stop && !mask_none;

   // Sequencer: w is only reloaded on cycles where e is (or becomes) high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         w          <= '0;
         e          <= 1'b1;
         s          <= 1'b0;
         busy       <= 1'b0;
         step_pulse <= 1'b0;
         done       <= 1'b0;
         blank_cnt  <= '0;
         dwell_cnt  <= '0;
         dwell_lat  <= '0;
      end else begin
         step_pulse <= 1'b0;
         done       <= 1'b0;
         if (stop) begin
            state <= IDLE;
            e     <= 1'b1;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  e <= 1'b1;
                  if (start_ok) begin
                     s         <= pol_in;
                     dwell_lat <= dwell_eff;
                     w         <= first_idx;
                     blank_cnt <= BLANK_LD;
                     busy      <= 1'b1;
                     state     <= BLANK;
                  end
               end
               BLANK: begin
                  if (blank_cnt <= BLANK_CNT_W'(1)) begin
                     e          <= 1'b0;
                     step_pulse <= 1'b1;
                     dwell_cnt  <= dwell_lat;
                     state      <= DWELL;
                  end else begin
                     blank_cnt <= blank_cnt - 1'b1;
                  end
               end
               DWELL: begin
                  if (dwell_cnt <= DWELL_ONE) begin
                     e <= 1'b1;
                     // An empty mask ends the scan like a wrap, but only one-shot reports done.
                     if (mask_none || (adv_wrap && !mode)) begin
                        done  <= !mode;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        w         <= next_idx;
                        blank_cnt <= BLANK_LD;
                        state     <= BLANK;
                     end
                  end else begin
                     dwell_cnt <= dwell_cnt - 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  e     <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
